// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Writer side of the CPU instruction-memory initialize port.
//             Receives a byte stream (16-bit little-endian word count header
//             followed by big-endian 32-bit instruction words), writes each
//             assembled word through the initialize port and keeps the CPU
//             in reset until the load has completed.
//  Options  : LOADER_CHECKSUM_EN - when defined, a trailing XOR checksum byte
//             over all payload bytes is required after the last word.
//  Ports    : clk, rst (async, active-low)
//             in_valid / in_data[7:0] / in_ready  - byte stream handshake
//             reload                              - restart from DONE/ERROR
//             initialize, instruction_initialize_data[31:0],
//             instruction_initialize_address[31:0] - memory write port
//             cpu_hold, done, error               - load status
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        reload,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_WORD  = 3'd2,
        S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_count_lo;   // header low byte, held until the high byte arrives
    logic [15:0] r_count;      // number of words in this load
    logic [15:0] r_word_idx;   // index of the word currently being assembled
    logic [1:0]  r_byte_idx;   // byte position inside the current word
    logic [23:0] r_shift;      // first three bytes of the current word
    logic [31:0] r_data;
    logic [31:0] r_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_accept;
    logic [15:0] w_hdr_count;
    logic        w_more_words;

    assign w_hdr_count  = {in_data, r_count_lo};
    assign w_accept     = in_valid & in_ready;
    // Widened by one bit so a count of 16'hFFFF cannot wrap the comparison.
    assign w_more_words = ({1'b0, r_word_idx} + 17'd1) < {1'b0, r_count};

    // in_ready depends on state alone; rst gating keeps it low while the
    // loader is held in reset (the reset state itself accepts bytes).
    assign in_ready = rst & ((r_state == S_HDR0) || (r_state == S_HDR1) ||
`ifdef LOADER_CHECKSUM_EN
                             (r_state == S_CHK) ||
`endif
                             (r_state == S_WORD));

    assign instruction_initialize_data    = r_data;
    assign instruction_initialize_address = r_addr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs. in_valid is used directly
    // here: every state that consumes a byte has in_ready=1 whenever rst
    // is released, and while rst is low the next state is discarded.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        initialize   = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;

        case (r_state)
            S_HDR0: begin
                if (in_valid) begin
                    w_next_state = S_HDR1;
                end
            end

            S_HDR1: begin
                if (in_valid) begin
                    if (w_hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next_state = S_CHK;
`else
                        w_next_state = S_DONE;
`endif
                    end else if ({1'b0, w_hdr_count} > c_max_words) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_next_state = S_WORD;
                    end
                end
            end

            S_WORD: begin
                if (in_valid && (r_byte_idx == 2'd3)) begin
                    w_next_state = S_WRITE;
                end
            end

            S_WRITE: begin
                initialize = 1'b1;
                if (w_more_words) begin
                    w_next_state = S_WORD;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    w_next_state = S_CHK;
`else
                    w_next_state = S_DONE;
`endif
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (in_valid) begin
                    w_next_state = (in_data == r_csum) ? S_DONE : S_ERROR;
                end
            end
`endif

            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (reload) begin
                    w_next_state = S_HDR0;
                end
            end

            S_ERROR: begin
                error = 1'b1;
                if (reload) begin
                    w_next_state = S_HDR0;
                end
            end

            default: begin
                w_next_state = S_HDR0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: header capture, word assembly, write data/address.
    // Data and address are loaded on the edge that accepts the 4th byte
    // so they are already stable for the whole WRITE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count_lo <= 8'd0;
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 24'd0;
            r_data     <= 32'd0;
            r_addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_HDR0: begin
                    if (w_accept) begin
                        r_count_lo <= in_data;
                    end
                end

                S_HDR1: begin
                    if (w_accept) begin
                        r_count    <= w_hdr_count;
                        r_word_idx <= 16'd0;
                        r_byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end

                S_WORD: begin
                    if (w_accept) begin
                        r_shift    <= {r_shift[15:0], in_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ in_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_data <= {r_shift, in_data};
                            r_addr <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                        end
                    end
                end

                S_WRITE: begin
                    r_word_idx <= r_word_idx + 16'd1;
                end

                S_DONE, S_ERROR: begin
                    if (reload) begin
                        r_count_lo <= 8'd0;
                        r_count    <= 16'd0;
                        r_word_idx <= 16'd0;
                        r_byte_idx <= 2'd0;
                        r_addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Streams directed and
//             randomised loads (with random in_valid gaps) and compares every
//             write strobe and the final status against a word-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          MAX_WORDS = 64;
`ifdef LOADER_CHECKSUM_EN
    localparam bit          CSUM_EN   = 1'b1;
`else
    localparam bit          CSUM_EN   = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        initialize;
    logic [31:0] instruction_initialize_data;
    logic [31:0] instruction_initialize_address;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_double = 0;
    logic        prev_init = 1'b0;

    logic [31:0] words[$];   // payload of the next load
    logic [63:0] wr_q[$];    // observed writes {address, data}
    logic [63:0] exp_q[$];   // expected writes {address, data}

    imem_loader #(
        .BASE_ADDR (BASE_ADDR),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .in_valid                       (in_valid),
        .in_data                        (in_data),
        .in_ready                       (in_ready),
        .reload                         (reload),
        .initialize                     (initialize),
        .instruction_initialize_data    (instruction_initialize_data),
        .instruction_initialize_address (instruction_initialize_address),
        .cpu_hold                       (cpu_hold),
        .done                           (done),
        .error                          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (initialize) begin
            wr_q.push_back({instruction_initialize_address, instruction_initialize_data});
            if (prev_init) n_double <= n_double + 1;
        end
        prev_init <= initialize;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the byte
    // was accepted. gap is the percent chance of idling a cycle first.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        while (gap > 0 && $urandom_range(99) < gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    task automatic run_load(input int cnt, input int gap, input bit bad_csum);
        logic [7:0]  cs;
        logic [15:0] hdr;
        logic [31:0] w;
        logic [31:0] a;
        bit          hdr_err;
        bit          exp_err;
        int          k;
        cs      = 8'h00;
        hdr     = cnt[15:0];
        hdr_err = (cnt > MAX_WORDS);
        exp_err = hdr_err || (CSUM_EN && bad_csum);
        wr_q.delete();
        exp_q.delete();
        send_byte(hdr[7:0], gap);
        send_byte(hdr[15:8], gap);
        if (hdr_err) begin
            check("hdr_err_now", {31'd0, error}, 32'd1);
        end else begin
            for (int i = 0; i < cnt; i++) begin
                w = words[i];
                a = BASE_ADDR + 32'(4 * i);
                for (int b = 3; b >= 0; b--) begin
                    send_byte(w[8*b +: 8], gap);
                    cs = cs ^ w[8*b +: 8];
                end
                check("wr_strobe", {31'd0, initialize}, 32'd1);
                check("wr_data", instruction_initialize_data, w);
                check("wr_addr", instruction_initialize_address, a);
                exp_q.push_back({a, w});
            end
            if (CSUM_EN) send_byte(cs ^ {7'd0, bad_csum}, gap);
        end
        k = 0;
        while (!(done || error) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("end_done",  {31'd0, done},     {31'd0, !exp_err});
        check("end_error", {31'd0, error},    {31'd0, exp_err});
        check("end_hold",  {31'd0, cpu_hold}, {31'd0, exp_err});
        check("end_ready", {31'd0, in_ready}, 32'd0);
        check("n_pulses",  wr_q.size(),       exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_q.size()) begin
                check("log_addr", wr_q[i][63:32], exp_q[i][63:32]);
                check("log_data", wr_q[i][31:0],  exp_q[i][31:0]);
            end
        end
        if (!exp_err && cnt > 0) begin
            check("keep_data", instruction_initialize_data, words[cnt-1]);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("rl_done",  {31'd0, done},     32'd0);
        check("rl_error", {31'd0, error},    32'd0);
        check("rl_hold",  {31'd0, cpu_hold}, 32'd1);
        check("rl_ready", {31'd0, in_ready}, 32'd1);
        check("rl_addr",  instruction_initialize_address, BASE_ADDR);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold",  {31'd0, cpu_hold},   32'd1);
        check("rst_init",  {31'd0, initialize}, 32'd0);
        check("rst_done",  {31'd0, done},       32'd0);
        check("rst_error", {31'd0, error},      32'd0);
        check("rst_ready", {31'd0, in_ready},   32'd0);
        check("rst_addr",  instruction_initialize_address, BASE_ADDR);
        check("rst_data",  instruction_initialize_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready", {31'd0, in_ready}, 32'd1);

        // Directed two-word load, without and with in_valid gaps.
        words = '{32'h2008_0005, 32'h2009_0007};
        run_load(2, 0, 1'b0);
        do_reload();
        run_load(2, 40, 1'b0);
        do_reload();

        // Header beyond MAX_WORDS, then the largest legal count.
        words.delete();
        run_load(MAX_WORDS + 1, 0, 1'b0);
        do_reload();
        fill_random(MAX_WORDS);
        run_load(MAX_WORDS, 10, 1'b0);
        do_reload();

        // Empty load.
        words.delete();
        run_load(0, 0, 1'b0);
        do_reload();
        if (CSUM_EN) begin
            run_load(0, 0, 1'b1);
            do_reload();
            fill_random(2);
            run_load(2, 20, 1'b1);
            do_reload();
        end

        // Randomised loads.
        for (int t = 0; t < 5; t++) begin
            fill_random($urandom_range(1, 6));
            run_load(words.size(), 30, 1'b0);
            do_reload();
        end

        // Reset in the middle of the second word of a three-word load.
        fill_random(3);
        wr_q.delete();
        send_byte(8'd3, 0);
        send_byte(8'd0, 0);
        for (int b = 3; b >= 0; b--) send_byte(words[0][8*b +: 8], 0);
        send_byte(words[1][31:24], 0);
        send_byte(words[1][23:16], 0);
        rst = 1'b0;
        #1;
        check("mid_init",  {31'd0, initialize}, 32'd0);
        check("mid_hold",  {31'd0, cpu_hold},   32'd1);
        check("mid_done",  {31'd0, done},       32'd0);
        check("mid_error", {31'd0, error},      32'd0);
        check("mid_ready", {31'd0, in_ready},   32'd0);
        check("mid_addr",  instruction_initialize_address, BASE_ADDR);
        check("mid_data",  instruction_initialize_data, 32'd0);
        check("mid_nwr",   wr_q.size(), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_random(3);
        run_load(3, 25, 1'b0);

        check("pulse_width", n_double, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
